// File: rtl/bcd_countdown_timer_pkg.sv
// timer_pkg
//   Shared definitions for the BCD phase timer: the FSM state encoding, the
//   largest legal BCD digit value and a helper that clamps a raw nibble into
//   the BCD range.
//   Ports: none (package).
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Nibbles A..F are not decimal digits; they saturate to 9 on load.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit_dn.sv
// bcd_digit_dn
//   One BCD digit of the down-counter chain. A borrow request from the
//   digit below decrements this digit; a digit at 0 wraps to 9 and passes
//   the borrow on to the digit above.
//   Ports:
//     clk_i, rst_i    clock, asynchronous active-high reset
//     load_i          overwrite the digit with load_digit_i (wins over borrow)
//     load_digit_i    value to load, already in BCD range
//     borrow_in_i     decrement request from the lower digit (or the tick)
//     borrow_out_o    decrement request passed to the next digit
//     digit_o         current digit value
module bcd_digit_dn
    import timer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_digit_i,
    input  logic       borrow_in_i,
    output logic       borrow_out_o,
    output logic [3:0] digit_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Wrap 0 -> 9 instead of subtracting, so the digit never leaves BCD range.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_digit_i;
        end else if (borrow_in_i) begin
            digit_d = (digit_q == 4'd0) ? BCD_MAX : (digit_q - 4'd1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign borrow_out_o = borrow_in_i && (digit_q == 4'd0);
    assign digit_o      = digit_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   Phase timer for the traffic light controller. Counts a loaded BCD value
//   down to zero, one step per TICK_DIV clock cycles, with start / pause /
//   resume control and a one-cycle time_out_o pulse on expiry.
//   Optional feature: define BCD_TIMER_AUTO_RELOAD_EN to reload the last
//   loaded value on expiry and keep running.
//   Parameters: DIGITS (BCD digits), TICK_DIV (clock cycles per tick, >= 1)
//   Ports:
//     clk_i, rst_i    clock, asynchronous active-high reset
//     load_i          load load_val_i (digits clamped to 9) and stop
//     load_val_i      BCD start value, digit 0 in bits [3:0]
//     start_i         begin or resume counting
//     pause_i         suspend counting
//     count_o         current BCD value
//     running_o       high while counting
//     time_out_o      single-cycle expiry pulse
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50_000_000
)
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    input  logic                  start_i,
    input  logic                  pause_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  running_o,
    output logic                  time_out_o
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    timer_state_t  state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  reload_q;
    logic          running_q, running_d;
    logic          timeOut_q, timeOut_d;

    logic          digLoad;
    logic [W-1:0]  digLoadVal;
    logic [W-1:0]  loadValClamped;
    logic          decEn;
    logic [DIGITS:0] borrow;
    logic          unused_borrow;
    logic          countIsZero;
    logic          countIsOne;
    logic          reloadIsZero;

    assign countIsZero  = (count_o == '0);
    assign countIsOne   = (count_o == W'(1));
    assign reloadIsZero = (reload_q == '0);

    // Digits share one load strobe; the value is the clamped input on an
    // explicit load, otherwise the reload register (used by auto-reload).
    assign digLoadVal = load_i ? loadValClamped : reload_q;
    assign borrow[0]  = decEn;

    // The top borrow would signal underflow; decrements are never issued at
    // zero, so it is intentionally left unused.
    assign unused_borrow = borrow[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign loadValClamped[4*i +: 4] = bcd_clamp(load_val_i[4*i +: 4]);

        bcd_digit_dn u_digit (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .load_i       (digLoad),
            .load_digit_i (digLoadVal[4*i +: 4]),
            .borrow_in_i  (borrow[i]),
            .borrow_out_o (borrow[i+1]),
            .digit_o      (count_o[4*i +: 4])
        );
    end

    // Next-state logic. Priority is load > start > pause. Expiry either comes
    // from a tick taking the count from 1 to 0, or from a start while the
    // count is already 0 (which expires without decrementing).
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        timeOut_d = 1'b0;
        digLoad   = 1'b0;
        decEn     = 1'b0;

        if (load_i) begin
            digLoad = 1'b1;
            presc_d = '0;
            state_d = IDLE;
        end else if (start_i && (state_q != RUN)) begin
            // Resuming from PAUSE keeps the partial tick interval.
            if (state_q != PAUSE) begin
                presc_d = '0;
            end
            if (countIsZero) begin
                timeOut_d = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                if (!reloadIsZero) begin
                    digLoad = 1'b1;
                    presc_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = DONE;
                end
`else
                state_d = DONE;
`endif
            end else begin
                state_d = RUN;
            end
        end else if (pause_i && !start_i && (state_q == RUN)) begin
            state_d = PAUSE;
        end else if (state_q == RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (countIsOne) begin
                    timeOut_d = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                    if (!reloadIsZero) begin
                        digLoad = 1'b1;
                    end else begin
                        decEn   = 1'b1;
                        state_d = DONE;
                    end
`else
                    decEn   = 1'b1;
                    state_d = DONE;
`endif
                end else if (!countIsZero) begin
                    decEn = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        running_d = (state_d == RUN);
    end

    // State, prescaler, reload register and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            reload_q  <= '0;
            running_q <= 1'b0;
            timeOut_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            timeOut_q <= timeOut_d;
            if (load_i) begin
                reload_q <= loadValClamped;
            end
        end
    end

    assign running_o  = running_q;
    assign time_out_o = timeOut_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
//   Self-checking bench for bcd_countdown_timer (DIGITS=2, TICK_DIV=4).
//   A decimal-integer reference model predicts the outputs for every driven
//   cycle; predictions are queued and compared after the following edge.
//   Honours BCD_TIMER_AUTO_RELOAD_EN when defined.
`timescale 1ns/1ps
module tb_bcd_countdown_timer;

   localparam int DIGITS   = 2;
   localparam int TICK_DIV = 4;

   localparam int ST_IDLE  = 0;
   localparam int ST_RUN   = 1;
   localparam int ST_PAUSE = 2;
   localparam int ST_DONE  = 3;

   typedef struct {
      logic [7:0] count;
      logic       running;
      logic       timeOut;
   } expect_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [7:0] loadVal = 8'h00;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [7:0] count;
   logic       running;
   logic       timeOut;

   expect_t expQ[$];
   int errors = 0;
   int checks = 0;
   int pulseCount = 0;

   int   mVal = 0;
   int   mReload = 0;
   int   mState = ST_IDLE;
   int   mPresc = 0;
   logic mTo = 1'b0;

   bcd_countdown_timer #(
      .DIGITS   (DIGITS),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (load),
      .load_val_i (loadVal),
      .start_i    (start),
      .pause_i    (pause),
      .count_o    (count),
      .running_o  (running),
      .time_out_o (timeOut)
   );

   // 100 MHz free-running clock
   always #5 clk = ~clk;

   // Counts one comparison and reports it when the DUT disagrees
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Decimal value of a BCD byte after clamping each digit to 9
   function automatic int clampDec(input logic [7:0] v);
      int tens;
      int ones;
      tens = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
      ones = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
      return tens * 10 + ones;
   endfunction

   function automatic logic [7:0] toBcd(input int v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(v / 10);
      ones = 4'(v % 10);
      return {tens, ones};
   endfunction

   task automatic modelReset();
      mVal = 0;
      mReload = 0;
      mState = ST_IDLE;
      mPresc = 0;
      mTo = 1'b0;
   endtask

   task automatic modelExpire();
      mTo = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      if (mReload != 0) begin
         mVal = mReload;
         mState = ST_RUN;
         mPresc = 0;
      end else begin
         mState = ST_DONE;
      end
`else
      mState = ST_DONE;
`endif
   endtask

   // Reference behaviour for one clock edge with the given inputs
   task automatic modelStep(input logic ld, input logic [7:0] lv, input logic st, input logic ps);
      mTo = 1'b0;
      if (ld) begin
         mVal = clampDec(lv);
         mReload = mVal;
         mPresc = 0;
         mState = ST_IDLE;
      end else if (st && mState != ST_RUN) begin
         if (mState != ST_PAUSE) mPresc = 0;
         if (mVal == 0) modelExpire();
         else mState = ST_RUN;
      end else if (ps && !st && mState == ST_RUN) begin
         mState = ST_PAUSE;
      end else if (mState == ST_RUN) begin
         mPresc++;
         if (mPresc == TICK_DIV) begin
            mPresc = 0;
            if (mVal > 0) mVal--;
            if (mVal == 0) modelExpire();
         end
      end
   endtask

   // Drives one cycle of inputs, queues the prediction, returns after the edge
   task automatic applyStimulus(input logic ld, input logic [7:0] lv, input logic st, input logic ps);
      @(negedge clk);
      load = ld;
      loadVal = lv;
      start = st;
      pause = ps;
      modelStep(ld, lv, st, ps);
      expQ.push_back('{count: toBcd(mVal), running: (mState == ST_RUN), timeOut: mTo});
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Scoreboard: pop the prediction for each edge and compare the outputs
   always @(posedge clk) begin
      #1;
      if (timeOut === 1'b1) pulseCount++;
      if (expQ.size() > 0) begin
         expect_t e;
         e = expQ.pop_front();
         checkOutput("sb_count", 32'(count), 32'(e.count));
         checkOutput("sb_running", 32'(running), 32'(e.running));
         checkOutput("sb_time_out", 32'(timeOut), 32'(e.timeOut));
      end
   end

   // Directed scenarios
   initial begin
      $display("[TB] start");
      repeat (2) @(negedge clk);
      checkOutput("reset_count", 32'(count), 32'h00);
      checkOutput("reset_running", 32'(running), 32'h0);
      checkOutput("reset_time_out", 32'(timeOut), 32'h0);
      rst = 1'b0;
      modelReset();

      // Full countdown from 25
      applyStimulus(1'b1, 8'h25, 1'b0, 1'b0);
      checkOutput("load25_count", 32'(count), 32'h25);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("start_running", 32'(running), 32'h1);
      pulseCount = 0;
      idleCycles(3);
      checkOutput("before_first_tick", 32'(count), 32'h25);
      idleCycles(1);
      checkOutput("first_tick", 32'(count), 32'h24);
      idleCycles(96);
`ifndef BCD_TIMER_AUTO_RELOAD_EN
      checkOutput("expired_count", 32'(count), 32'h00);
      checkOutput("expired_pulses", 32'(pulseCount), 32'd1);
      checkOutput("expired_running", 32'(running), 32'h0);
`endif

      // Borrow across digits: 10 -> 09
      applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      idleCycles(3);
      checkOutput("ten_hold", 32'(count), 32'h10);
      idleCycles(1);
      checkOutput("ten_borrow", 32'(count), 32'h09);

      // Out-of-range digits clamp to 9
      applyStimulus(1'b1, 8'hAF, 1'b0, 1'b0);
      checkOutput("clamp_AF", 32'(count), 32'h99);
      checkOutput("clamp_running", 32'(running), 32'h0);

      // Pause mid-interval, resume keeps the partial interval
      applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      idleCycles(2);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("paused_running", 32'(running), 32'h0);
      idleCycles(19);
      checkOutput("paused_count", 32'(count), 32'h05);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      idleCycles(1);
      checkOutput("resume_hold", 32'(count), 32'h05);
      idleCycles(1);
      checkOutput("resume_tick", 32'(count), 32'h04);

      // load wins over start in the same cycle
      applyStimulus(1'b1, 8'h42, 1'b1, 1'b0);
      checkOutput("load_start_count", 32'(count), 32'h42);
      checkOutput("load_start_running", 32'(running), 32'h0);

      // start at zero expires at once without decrementing
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("zero_start_time_out", 32'(timeOut), 32'h1);
      checkOutput("zero_start_count", 32'(count), 32'h00);
      checkOutput("zero_start_running", 32'(running), 32'h0);
      idleCycles(2);

      // Asynchronous reset mid-run at 13
      applyStimulus(1'b1, 8'h15, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      idleCycles(9);
      checkOutput("pre_reset_count", 32'(count), 32'h13);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_count", 32'(count), 32'h00);
      checkOutput("async_reset_running", 32'(running), 32'h0);
      checkOutput("async_reset_time_out", 32'(timeOut), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      idleCycles(2);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
      // Auto-reload: expiry every 12 cycles, keeps running
      applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      pulseCount = 0;
      idleCycles(36);
      checkOutput("reload_pulses", 32'(pulseCount), 32'd3);
      checkOutput("reload_count", 32'(count), 32'h03);
      checkOutput("reload_running", 32'(running), 32'h1);
`endif

      // Short pseudo-random tail against the model
      for (int i = 0; i < 60; i++) begin
         logic [7:0] v;
         int sel;
         v = 8'($urandom_range(0, 255));
         sel = int'($urandom_range(0, 19));
         applyStimulus(sel == 0, v, sel == 1 || sel == 2, sel == 3);
      end

      idleCycles(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
